// File: rtl/guess_game_pkg.sv
// rtl/guess_game_pkg.sv - shared state codes and field widths for the guessing game
package guess_game_pkg;

   localparam int LVL_W = 3;
   localparam int SEC_W = 4;
   localparam int TRY_W = 3;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE    = 4'd0;
   localparam state_t S_GREET   = 4'd1;
   localparam state_t S_LOAD    = 4'd2;
   localparam state_t S_PLAY    = 4'd3;
   localparam state_t S_JUDGE   = 4'd4;
   localparam state_t S_PASS    = 4'd5;
   localparam state_t S_FAIL    = 4'd6;
   localparam state_t S_VICTORY = 4'd7;

endpackage

// File: rtl/guess_game_ctrl_level_timer.sv
// rtl/guess_game_ctrl_level_timer.sv - per-level seconds countdown
// Loadable down-counter; a tick decrements it, saturating at zero.
module level_timer
   import guess_game_pkg::*;
#(
   parameter int W = SEC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_tick,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - multi-level number-guessing game controller
// Round sequencing, tries/hint tracking and target latch; countdown lives in level_timer.
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int NUM_LEVELS = 3,
   parameter int BASE_BITS  = 5,
   parameter int GUESS_W    = 7,
   parameter int LEVEL_SECS = 9,
   parameter int MAX_TRIES  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               start,
   input  logic               restart,
   input  logic               tick,
   input  logic [GUESS_W-1:0] guess,
   input  logic [GUESS_W-1:0] rand_num,
   output logic               rand_load,
   output logic [3:0]         state,
   output logic [LVL_W-1:0]   level,
   output logic [SEC_W-1:0]   secs_left,
   output logic [TRY_W-1:0]   tries_left,
   output logic               hint_hi,
   output logic               hint_lo,
   output logic               win,
   output logic               fail,
   output logic               beep_req
);

   localparam logic [7:0] BASE_SHIFT = 8'(BASE_BITS);

   state_t             r_state;
   state_t             w_next;
   logic               r_entry;
   logic [LVL_W-1:0]   r_level;
   logic [TRY_W-1:0]   r_tries;
   logic [GUESS_W-1:0] r_target;
   logic [GUESS_W-1:0] r_guess;
   logic               r_hint_hi;
   logic               r_hint_lo;

   logic [SEC_W-1:0]   w_secs;
   logic               w_secs_zero;
   logic               w_timer_load;
   logic               w_timer_dec;
   logic [GUESS_W-1:0] w_mask;
   logic [GUESS_W-1:0] w_guess_m;
   logic               w_match;
   logic               w_last_level;
   logic               w_last_sec;
   logic               w_last_try;

   // Active width grows by one switch bit per level.
   assign w_mask       = ~({GUESS_W{1'b1}} << (BASE_SHIFT + 8'(r_level)));
   assign w_guess_m    = r_guess & w_mask;
   assign w_match      = (w_guess_m == r_target);
   assign w_last_level = (r_level == LVL_W'(NUM_LEVELS - 1));
   assign w_last_sec   = w_secs_zero || (w_secs == SEC_W'(1));
   assign w_last_try   = (r_tries == TRY_W'(1));

   // Start and restart both outrank the tick, so the timer freezes on those cycles.
   assign w_timer_load = enable && (r_state == S_LOAD);
   assign w_timer_dec  = enable && (r_state == S_PLAY) && tick && !restart && !start;

   level_timer #(
      .W (SEC_W)
   ) u_level_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_timer_load),
      .i_load_val (SEC_W'(LEVEL_SECS)),
      .i_tick     (w_timer_dec),
      .o_count    (w_secs),
      .o_zero     (w_secs_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_entry <= 1'b0;
      end else begin
         r_state <= w_next;
         r_entry <= (w_next != r_state);
      end
   end

   always_comb begin
      w_next = r_state;
      if (!enable) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_next = S_GREET;
            S_GREET: if (restart) w_next = S_LOAD;
            S_LOAD:  w_next = S_PLAY;
            S_PLAY: begin
               if (restart)                 w_next = S_LOAD;
               else if (start)              w_next = S_JUDGE;
               else if (tick && w_last_sec) w_next = S_FAIL;
            end
            S_JUDGE: begin
               if (w_match)         w_next = w_last_level ? S_VICTORY : S_PASS;
               else if (w_last_try) w_next = S_FAIL;
               else                 w_next = S_PLAY;
            end
            S_PASS:    w_next = S_LOAD;
            S_FAIL:    if (restart) w_next = S_LOAD;
            S_VICTORY: if (restart) w_next = S_LOAD;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rand_load = 1'b0;
      win       = 1'b0;
      fail      = 1'b0;
      beep_req  = 1'b0;
      case (r_state)
         S_LOAD:    rand_load = 1'b1;
         S_PASS:    beep_req  = r_entry;
         S_FAIL: begin
            fail     = 1'b1;
            beep_req = r_entry;
         end
         S_VICTORY: begin
            win      = 1'b1;
            beep_req = r_entry;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level   <= '0;
         r_tries   <= '0;
         r_target  <= '0;
         r_guess   <= '0;
         r_hint_hi <= 1'b0;
         r_hint_lo <= 1'b0;
      end else if (enable) begin
         case (r_state)
            S_GREET, S_FAIL, S_VICTORY: begin
               if (restart) r_level <= '0;
            end
            S_PLAY: begin
               if (restart)    r_level <= '0;
               else if (start) r_guess <= guess;
            end
            S_LOAD: begin
               r_target  <= rand_num & w_mask;
               r_tries   <= TRY_W'(MAX_TRIES);
               r_hint_hi <= 1'b0;
               r_hint_lo <= 1'b0;
            end
            S_JUDGE: begin
               if (!w_match) begin
                  r_hint_hi <= (w_guess_m > r_target);
                  r_hint_lo <= (w_guess_m < r_target);
                  r_tries   <= r_tries - TRY_W'(1);
               end
            end
            S_PASS:  r_level <= r_level + LVL_W'(1);
            default: ;
         endcase
      end
   end

   assign state      = r_state;
   assign level      = r_level;
   assign secs_left  = w_secs;
   assign tries_left = r_tries;
   assign hint_hi    = r_hint_hi;
   assign hint_lo    = r_hint_lo;

endmodule
